trimdac_scheduler: RTL



---
 rtl/trimdac_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/trimdac_scheduler.sv
// Command scheduler for the AD8804 TrimDAC serializer: shadows all channel codes and sends dirty ones round-robin.
// Optional build macro TRIMDAC_REFRESH_EN adds a periodic re-send of every channel.
module trimdac_scheduler #(
    parameter int          NUM_CH         = 12,
    parameter logic [7:0]  RESET_CODE     = 8'h80,
    parameter int          LATCH_CYCLES   = 2,
    parameter int          BUSY_TIMEOUT   = 64,
    parameter logic [23:0] REFRESH_CYCLES = 24'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_err,
    output logic       dac_latch,
    output logic [3:0] dac_address,
    output logic [7:0] dac_value,
    input  logic       dac_busy,
    output logic       pending,
    output logic       timeout_err,
    input  logic       err_clr,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int              CNT_MAX   = (BUSY_TIMEOUT > LATCH_CYCLES) ? BUSY_TIMEOUT : LATCH_CYCLES;
    localparam int              CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUSY_END  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [3:0]      CH_LIMIT  = 4'(NUM_CH);
    localparam logic [3:0]      LAST_CH   = 4'(NUM_CH - 1);
    localparam logic [4:0]      CH_WRAP   = 5'(NUM_CH);

    if (LATCH_CYCLES < 1 || BUSY_TIMEOUT < 1 || REFRESH_CYCLES == 24'd0) begin : g_bad_param
        $error("trimdac_scheduler: invalid parameter value");
    end

    state_t           state_q;
    logic [7:0]       shadow_q [NUM_CH];
    logic [NUM_CH-1:0] dirty_q;
    logic [3:0]       last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             latch_q;
    logic [3:0]       addr_q;
    logic [7:0]       value_q;
    logic             wr_err_q;
    logic             timeout_q;

    logic             sel_found;
    logic [3:0]       sel_ch;
    logic [4:0]       cand;
    logic             wr_ok;

    assign wr_ok = wr_en && (wr_addr < CH_LIMIT);

    // First dirty channel scanning upward from the one after last_q, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = 5'(last_q) + 5'(i);
            if (cand >= CH_WRAP) begin
                cand = cand - CH_WRAP;
            end
            if (!sel_found && dirty_q[cand[3:0]]) begin
                sel_found = 1'b1;
                sel_ch    = cand[3:0];
            end
        end
    end

`ifdef TRIMDAC_REFRESH_EN
    logic [23:0] refresh_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RESET_CODE;
            end
            dirty_q   <= '1;
            last_q    <= LAST_CH;
            cnt_q     <= '0;
            latch_q   <= 1'b0;
            addr_q    <= '0;
            value_q   <= '0;
            wr_err_q  <= 1'b0;
            timeout_q <= 1'b0;
`ifdef TRIMDAC_REFRESH_EN
            refresh_q <= '0;
`endif
        end else begin
            wr_err_q <= wr_en && !wr_ok;
            if (err_clr) begin
                timeout_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        addr_q          <= sel_ch;
                        value_q         <= shadow_q[sel_ch];
                        dirty_q[sel_ch] <= 1'b0;
                        last_q          <= sel_ch;
                        latch_q         <= 1'b1;
                        cnt_q           <= '0;
                        state_q         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_q == LATCH_END) begin
                        latch_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= WAIT_BUSY;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (dac_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == BUSY_END) begin
                        // Serializer never answered: flag it and retry this channel later.
                        timeout_q       <= 1'b1;
                        dirty_q[addr_q] <= 1'b1;
                        state_q         <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!dac_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

`ifdef TRIMDAC_REFRESH_EN
            if (refresh_q == REFRESH_CYCLES - 24'd1) begin
                refresh_q <= '0;
                dirty_q   <= '1;
            end else begin
                refresh_q <= refresh_q + 24'd1;
            end
`endif

            // Host writes come last so a set always beats a same-cycle capture clear.
            if (wr_ok) begin
                shadow_q[wr_addr] <= wr_data;
                dirty_q[wr_addr]  <= 1'b1;
            end
        end
    end

    assign wr_err      = wr_err_q;
    assign dac_latch   = latch_q;
    assign dac_address = addr_q;
    assign dac_value   = value_q;
    assign timeout_err = timeout_q;
    assign pending     = (|dirty_q) || (state_q != IDLE);
    assign dbg_state_o = state_q;
endmodule
